// File: rtl/bsg_wormhole_test_checker.sv
// Wormhole demo traffic sink: parses header/body flits, checks coordinates, length
// and payload sequence, and exposes packet counts plus sticky error status.
module bsg_wormhole_test_checker #(
    parameter int width_p          = 32,
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int len_width_p      = 4,
    parameter int reserved_width_p = 4,
    parameter int length_p         = 3,
    parameter int count_width_p    = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic                      stall_en_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      valid_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      ready_o,
    output logic [count_width_p-1:0]  packet_count_o,
    output logic                      error_o,
    output logic [2:0]                error_code_o,
    output logic [width_p-1:0]        first_err_data_o,
    output logic                      busy_o
);

    localparam int y_lo_lp   = x_cord_width_p;
    localparam int len_lo_lp = x_cord_width_p + y_cord_width_p;

    typedef enum logic [0:0] {st_header, st_body} state_e;

    state_e                     state_r, state_s;
    logic [7:0]                 lfsr_r;
    logic [len_width_p-1:0]     remaining_r, remaining_s;
    logic [width_p-1:0]         expected_r, expected_s;
    logic [count_width_p-1:0]   count_r, count_s;
    logic [2:0]                 code_r, code_s, new_err_s;
    logic                       error_r, busy_r, first_load_s, transfer_s;
    logic [width_p-1:0]         first_err_r;
    logic [x_cord_width_p-1:0]  hdr_x_s;
    logic [y_cord_width_p-1:0]  hdr_y_s;
    logic [len_width_p-1:0]     hdr_len_s;

    function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] v);
        return (v == {count_width_p{1'b1}}) ? v : v + {{(count_width_p-1){1'b0}}, 1'b1};
    endfunction

    // Fibonacci taps 8,6,5,4 feed back into bit 0
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Stall pattern comes from registered state only, so ready never depends on valid_i
    assign ready_o          = reset_i & enable_i & ~(stall_en_i & lfsr_r[0]);
    assign transfer_s       = valid_i & ready_o;
    assign hdr_x_s          = data_i[x_cord_width_p-1:0];
    assign hdr_y_s          = data_i[y_lo_lp +: y_cord_width_p];
    assign hdr_len_s        = data_i[len_lo_lp +: len_width_p];
    assign packet_count_o   = count_r;
    assign error_o          = error_r;
    assign error_code_o     = code_r;
    assign first_err_data_o = first_err_r;
    assign busy_o           = busy_r;

    // Packet parser next-state: framing follows the received length, even when it is wrong
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        expected_s  = expected_r;
        count_s     = count_r;
        new_err_s   = 3'b000;
        if (transfer_s) begin
            case (state_r)
                st_header: begin
                    new_err_s[0] = (hdr_x_s != my_x_i) | (hdr_y_s != my_y_i);
                    new_err_s[1] = (hdr_len_s != len_width_p'(length_p));
                    remaining_s  = hdr_len_s;
                    if (hdr_len_s == {len_width_p{1'b0}}) begin
                        count_s = sat_inc(count_r);
                        state_s = st_header;
                    end else begin
                        state_s = st_body;
                    end
                end
                st_body: begin
                    new_err_s[2] = (data_i != expected_r);
                    expected_s   = data_i + {{(width_p-1){1'b0}}, 1'b1};
                    remaining_s  = remaining_r - {{(len_width_p-1){1'b0}}, 1'b1};
                    if (remaining_r == {{(len_width_p-1){1'b0}}, 1'b1}) begin
                        count_s = sat_inc(count_r);
                        state_s = st_header;
                    end else begin
                        state_s = st_body;
                    end
                end
                default: begin
                    state_s = st_header;
                end
            endcase
        end else begin
            state_s = state_r;
        end
        code_s       = code_r | new_err_s;
        first_load_s = (code_r == 3'b000) & (new_err_s != 3'b000);
    end

    // State, stall LFSR and sticky status registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r     <= st_header;
            lfsr_r      <= 8'h01;
            remaining_r <= {len_width_p{1'b0}};
            expected_r  <= {width_p{1'b0}};
            count_r     <= {count_width_p{1'b0}};
            code_r      <= 3'b000;
            error_r     <= 1'b0;
            first_err_r <= {width_p{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            lfsr_r      <= stall_en_i ? lfsr_step(lfsr_r) : lfsr_r;
            remaining_r <= remaining_s;
            expected_r  <= expected_s;
            count_r     <= count_s;
            code_r      <= code_s;
            error_r     <= |code_s;
            first_err_r <= first_load_s ? data_i : first_err_r;
            busy_r      <= (state_s == st_body);
        end
    end

endmodule
